// File: rtl/fir_post_pkg.sv
// Shared widths, saturation bounds and parameter defaults for the FIR output
// decimator, plus the round-and-saturate helper used by its stage register.
package fir_post_pkg;

    localparam int IN_W      = 16;
    localparam int OUT_W     = 8;
    localparam int SUM_W     = IN_W + 1;
    localparam int SAT_MAX   = 127;
    localparam int SAT_MIN   = -128;
    localparam int DECIM_DEF = 4;
    localparam int SHIFT_DEF = 4;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
    } rs_t;

    // 17-bit add cannot wrap: 32767 + 128 still fits, so the shift sees the true sum
    function automatic rs_t round_sat(input logic signed [IN_W-1:0] din, input int shift);
        logic signed [SUM_W-1:0] sum_s;
        logic signed [SUM_W-1:0] shr_s;
        rs_t                     res;
        sum_s = $signed(SUM_W'(din)) + $signed(SUM_W'(1) <<< (shift - 1));
        shr_s = sum_s >>> shift;
        if (shr_s > $signed(SUM_W'(SAT_MAX))) begin
            res.data = OUT_W'(SAT_MAX);
            res.sat  = 1'b1;
        end else if (shr_s < $signed(SUM_W'(SAT_MIN))) begin
            res.data = OUT_W'(SAT_MIN);
            res.sat  = 1'b1;
        end else begin
            res.data = shr_s[OUT_W-1:0];
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; a push while full only succeeds
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Accept/commit decisions for this edge
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign dout = mem_r[rd_ptr_r];

    // Storage array; cleared on reset so the head reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fir_output_decimator.sv
// Decimates FIR output samples, rounds and saturates them to 8 bits and
// queues them in an output FIFO; sticky flags report drops and clamps.
module fir_output_decimator
    import fir_post_pkg::*;
#(
    parameter int DECIM = DECIM_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    ovf,
    output logic                    sat
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]          phase_r;
    logic                   cap_valid_r;
    logic signed [IN_W-1:0] cap_data_r;
    logic                   stg_valid_r;
    logic [OUT_W-1:0]       stg_data_r;
    logic                   ovf_r;
    logic                   sat_r;
    logic                   keep_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [OUT_W-1:0]       fifo_dout_s;
    rs_t                    rs_s;

    // Keep decision, rounding of the captured sample, and handshake
    always_comb begin
        keep_s    = in_valid && (phase_r == {PW{1'b0}});
        rs_s      = round_sat(cap_data_r, SHIFT);
        out_valid = !fifo_empty_s;
        pop_s     = out_valid && out_ready;
    end

    // Phase counter advances only on valid input samples
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= {PW{1'b0}};
        end else if (in_valid) begin
            phase_r <= (phase_r == PW'(DECIM - 1)) ? {PW{1'b0}} : phase_r + PW'(1);
        end else begin
            phase_r <= phase_r;
        end
    end

    // Capture and stage registers; never stalled, so the input needs no back-pressure
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_r <= 1'b0;
            cap_data_r  <= {IN_W{1'b0}};
            stg_valid_r <= 1'b0;
            stg_data_r  <= {OUT_W{1'b0}};
        end else begin
            cap_valid_r <= keep_s;
            cap_data_r  <= keep_s ? in_data : cap_data_r;
            stg_valid_r <= cap_valid_r;
            stg_data_r  <= cap_valid_r ? rs_s.data : stg_data_r;
        end
    end

    // Sticky status: clamp seen at stage load, drop seen at a full push without pop
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            sat_r <= sat_r | (cap_valid_r & rs_s.sat);
            ovf_r <= ovf_r | (stg_valid_r & fifo_full_s & ~pop_s);
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stg_valid_r),
        .pop   (pop_s),
        .din   (stg_data_r),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign out_data = $signed(fifo_dout_s);
    assign ovf      = ovf_r;
    assign sat      = sat_r;

endmodule

// File: doc/fir_output_decimator.md
FIR_OUTPUT_DECIMATOR -- requirements
Module: fir_output_decimator

Interface
REQ-001 Parameter DECIM, default 4: decimation factor, range 1..16.
REQ-002 Parameter SHIFT, default 4: right-shift applied before narrowing, range 1..8.
REQ-003 Parameter DEPTH, default 4: output FIFO depth, a power of two and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_data carries a new filter output this cycle.
REQ-007 Port in_data, input, 16 bits, signed: FIR filter output sample.
REQ-008 Port out_valid, output, 1 bit: the FIFO head is presented on out_data.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the head.
REQ-010 Port out_data, output, 8 bits, signed: rounded and saturated sample.
REQ-011 Port ovf, output, 1 bit: sticky flag, a sample was dropped on FIFO full.
REQ-012 Port sat, output, 1 bit: sticky flag, a sample was saturated.

Function
REQ-013 A phase counter (0..DECIM-1) SHALL advance only on cycles with in_valid=1 and SHALL wrap to 0 after DECIM-1.
REQ-014 A sample SHALL be kept only when in_valid=1 and phase=0; all others are discarded, and DECIM=1 keeps every sample.
REQ-015 Rounding SHALL be r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in 17-bit signed arithmetic with no intermediate wrap.
REQ-016 Saturation SHALL clamp r to [-128, 127]; any clamp sets sat on the same edge the stage register loads.
REQ-017 Pipeline: a kept sample loads the stage register at edge t+1 and is pushed into the FIFO at edge t+2; with the FIFO empty, out_valid SHALL rise in the cycle after edge t+2.
REQ-018 There SHALL be no combinational path from in_* to out_*.
REQ-019 Pop SHALL occur on a rising edge when out_valid=1 and out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-021 FIFO order SHALL be strict first-in, first-out.
REQ-022 A push with the FIFO full and no pop in the same cycle SHALL drop the new sample, leave the FIFO contents unchanged, and set ovf.
REQ-023 A push with the FIFO full and a simultaneous pop SHALL succeed, with no drop and ovf unchanged.
REQ-024 A push into an empty FIFO SHALL have no bypass; out_valid rises on the following cycle.
REQ-025 Simultaneous push and pop at any occupancy SHALL leave the count unchanged.
REQ-026 The stage register SHALL never stall, so in_data is never back-pressured.
REQ-027 ovf and sat SHALL clear only on reset.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL clear: phase counter to 0, stage register to invalid, FIFO pointers and count to 0, out_valid=0, out_data=0, ovf=0, sat=0.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered samples.
REQ-030 The first in_valid=1 after reset deasserts SHALL be kept, since phase=0.
REQ-031 in_valid SHALL be ignored while reset=1.

Structure
REQ-032 Package fir_post_pkg SHALL hold: IN_W=16, OUT_W=8, SAT_MAX=127, SAT_MIN=-128, and the parameter defaults.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH, ports clk/reset/push/pop/din/dout/full/empty), instantiated once.

Verification
REQ-034 Decimation: DECIM=4, SHIFT=4, in_valid=1 continuously, in_data=0,16,32,...,176, out_ready=1 -> out_data=0,4,8 (from inputs 0, 64, 128), first out_valid 3 cycles after the first in_valid.
REQ-035 Rounding: DECIM=1, SHIFT=4, in_data=24, 23, -24, -8, -9 -> out_data=2, 1, -1, 0, -1; sat stays 0.
REQ-036 Saturation: DECIM=1, in_data=3000 then -3000 -> out_data=127 then -128; sat=1 from the first saturating sample onward.
REQ-037 Backpressure/overflow: DECIM=1, out_ready=0, six samples 16,32,48,64,80,96 -> FIFO holds 1,2,3,4; samples 5,6 dropped; ovf=1. Then raising out_ready=1 -> out_data=1,2,3,4 on consecutive cycles, after which out_valid=0.
REQ-038 Full push+pop: FIFO full, out_ready=1, in_valid=1 with a kept sample -> no drop, ovf stays 0, count stays DEPTH.
REQ-039 Reset mid-stream plus gapped input: 3 entries queued, reset pulsed for 1 cycle -> next cycle out_valid=0 and ovf=0. Afterwards, with in_valid toggling 1,0,1,0,... and DECIM=2, only the 1st, 3rd, 5th valid samples are output.
